// File: rtl/mux2to1_arbiter_if.sv
// mux2to1_arbiter_if: request/data and grant/result signals between two producers and the arbiter.
interface mux2to1_arbiter_if #(parameter int WIDTH = 16);
  logic             req1;
  logic             req2;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             gnt1;
  logic             gnt2;
  logic             switch;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  modport master (
    output req1, req2, input1, input2,
    input  gnt1, gnt2, switch, out, out_valid
  );
  modport slave (
    input  req1, req2, input1, input2,
    output gnt1, gnt2, switch, out, out_valid
  );
endinterface

// File: rtl/mux2to1_arbiter.sv
// mux2to1_arbiter: two-requester arbiter driving a registered 2:1 datapath mux, round-robin with bounded hold.
// Defining MUX_ARB_PRIORITY_EN switches to fixed priority for requester 1.
module mux2to1_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux2to1_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, G1, G2} state_t;
  state_t           state, nxt;
  logic [7:0]       hold_cnt;
  logic             xfer1, xfer2, xfer, at_max;
  logic [WIDTH-1:0] word;
  assign xfer1  = state == G1 && bus.req1;
  assign xfer2  = state == G2 && bus.req2;
  assign xfer   = xfer1 || xfer2;
  assign word   = xfer1 ? bus.input1 : bus.input2;
  assign at_max = hold_cnt == 8'(MAX_HOLD - 1);
`ifdef MUX_ARB_PRIORITY_EN
  // Requester 1 preempts from every state; requester 2 only gets idle slots.
  always_comb nxt = bus.req1 ? G1 : bus.req2 ? G2 : IDLE;
`else
  logic [1:0] last;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = (bus.req1 && bus.req2) ? (last == 2'd1 ? G2 : G1) : bus.req1 ? G1 : bus.req2 ? G2 : IDLE;
    else if (state == G1)
      nxt = !bus.req1 ? (bus.req2 ? G2 : IDLE) : (bus.req2 && at_max) ? G2 : G1;
    else
      nxt = !bus.req2 ? (bus.req1 ? G1 : IDLE) : (bus.req1 && at_max) ? G1 : G2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 2'd2;
    else if (nxt != state && state != IDLE) last <= state == G1 ? 2'd1 : 2'd2;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      bus.gnt1      <= 1'b0;
      bus.gnt2      <= 1'b0;
      bus.switch    <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= nxt;
      hold_cnt      <= nxt != state ? '0 : (xfer && !at_max) ? hold_cnt + 8'd1 : hold_cnt;
      bus.gnt1      <= nxt == G1;
      bus.gnt2      <= nxt == G2;
      bus.switch    <= nxt == G1;
      bus.out_valid <= xfer;
      if (xfer) bus.out <= word;
    end
endmodule

// File: tb/tb_mux2to1_arbiter.sv
// tb_mux2to1_arbiter: vector table, directed corner cases and random traffic against a tenure-count model,
// run on a MAX_HOLD=4 and a MAX_HOLD=1 instance sharing the same stimulus.
module tb_mux2to1_arbiter;
`ifdef MUX_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk, rst_n, r1, r2;
  logic [15:0] d1, d2;
  int errors, checks;

  mux2to1_arbiter_if #(.WIDTH(16)) b4 ();
  mux2to1_arbiter_if #(.WIDTH(16)) b1 ();
  assign b4.req1 = r1;
  assign b4.req2 = r2;
  assign b4.input1 = d1;
  assign b4.input2 = d2;
  assign b1.req1 = r1;
  assign b1.req2 = r2;
  assign b1.input1 = d1;
  assign b1.input2 = d2;

  mux2to1_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux2to1_arbiter #(.WIDTH(16), .MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // owner 0 = nobody; served = words moved in the current tenure, never capped
  typedef struct {
    int          owner;
    int          served;
    int          last;
    logic [15:0] out;
    bit          vld;
  } mdl_t;
  mdl_t m[2];
  int hold_of[2] = '{4, 1};

  function automatic mdl_t reset_model();
    mdl_t s;
    s.owner = 0; s.served = 0; s.last = 2; s.out = '0; s.vld = 1'b0;
    return s;
  endfunction

  function automatic mdl_t step_model(mdl_t s, int mh, bit a, bit b, logic [15:0] x, logic [15:0] y);
    mdl_t n = s;
    int want;
    bit mine, other, moved;
    mine  = s.owner == 1 ? a : b;
    other = s.owner == 1 ? b : a;
    moved = s.owner != 0 && mine;
    n.vld = moved;
    if (moved) n.out = s.owner == 1 ? x : y;
    n.served = s.served + (moved ? 1 : 0);
    if (PRIO) want = a ? 1 : b ? 2 : 0;
    else if (s.owner == 0) want = (a && b) ? 3 - s.last : a ? 1 : b ? 2 : 0;
    else if (!mine) want = other ? 3 - s.owner : 0;
    else want = (other && n.served >= mh) ? 3 - s.owner : s.owner;
    if (want != s.owner) begin
      if (s.owner != 0) n.last = s.owner;
      n.served = 0;
    end
    n.owner = want;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input int k, input logic g1, input logic g2, input logic sw, input logic v, input logic [15:0] o);
    chk(k == 0 ? "grants_h4" : "grants_h1", {29'd0, g1, g2, sw},
        {29'd0, m[k].owner == 1, m[k].owner == 2, m[k].owner == 1});
    chk(k == 0 ? "valid_h4" : "valid_h1", {31'd0, v}, {31'd0, m[k].vld});
    chk(k == 0 ? "out_h4" : "out_h1", {16'd0, o}, {16'd0, m[k].out});
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) m[k] = step_model(m[k], hold_of[k], r1, r2, d1, d2);
    @(posedge clk);
    #1;
    cmp_model(0, b4.gnt1, b4.gnt2, b4.switch, b4.out_valid, b4.out);
    cmp_model(1, b1.gnt1, b1.gnt2, b1.switch, b1.out_valid, b1.out);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    m[0] = reset_model();
    m[1] = reset_model();
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          r1, r2;
    logic [15:0] d1, d2;
    bit          g1, g2, v;
    logic [15:0] o;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [15:0] q[$], q1[$];
    int g2_cycles;
    errors = 0; checks = 0;
    rst_n = 1'b0; r1 = 1'b0; r2 = 1'b0; d1 = '0; d2 = '0;
    m[0] = reset_model();
    m[1] = reset_model();
    tbl[0] = '{1, 0, 16'hABCD, 16'h0000, 1, 0, 0, 16'h0000};
    tbl[1] = '{1, 0, 16'hABCD, 16'h0000, 1, 0, 1, 16'hABCD};
    tbl[2] = '{1, 0, 16'hABCD, 16'h0000, 1, 0, 1, 16'hABCD};
    tbl[3] = '{0, 1, 16'h0000, 16'h1234, 0, 1, 0, 16'hABCD};
    tbl[4] = '{0, 1, 16'h0000, 16'h1234, 0, 1, 1, 16'h1234};
    tbl[5] = '{0, 1, 16'h0000, 16'h5678, 0, 1, 1, 16'h5678};
    tbl[6] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5678};
    tbl[7] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5678};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {27'd0, b4.gnt1, b4.gnt2, b4.switch, b4.out_valid, |b4.out}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      r1 = tbl[i].r1; r2 = tbl[i].r2; d1 = tbl[i].d1; d2 = tbl[i].d2;
      tick();
      chk($sformatf("vec%0d_gnt", i), {30'd0, b4.gnt1, b4.gnt2}, {30'd0, tbl[i].g1, tbl[i].g2});
      chk($sformatf("vec%0d_sw", i), {31'd0, b4.switch}, {31'd0, tbl[i].g1});
      chk($sformatf("vec%0d_out", i), {15'd0, b4.out_valid, b4.out}, {15'd0, tbl[i].v, tbl[i].o});
    end

    // Tie from IDLE: requester 1 first, then hold-bounded rotation (or pure priority)
    pulse_reset();
    r1 = 1'b1; r2 = 1'b1; d1 = 16'hBBBB; d2 = 16'hCCCC;
    g2_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) chk("tie_first_gnt1", {31'd0, b4.gnt1}, 32'd1);
      if (b4.out_valid) q.push_back(b4.out);
      if (b4.gnt2) g2_cycles++;
    end
    chk("tie_words", q.size(), 5);
    for (int i = 0; i < q.size() && i < 5; i++)
      chk($sformatf("tie_word%0d", i), {16'd0, q[i]}, {16'd0, (PRIO || i < 4) ? 16'hBBBB : 16'hCCCC});
    chk("tie_gnt2_cycles", g2_cycles, PRIO ? 0 : 2);

    // MAX_HOLD=1 instance alternates every cycle under continuous contention
    d1 = 16'hAAAA; d2 = 16'h5555;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b1.out_valid) q1.push_back(b1.out);
    end
    chk("alt_words", q1.size(), 8);
    for (int i = 0; i < q1.size(); i++)
      chk($sformatf("alt_word%0d", i), {16'd0, q1[i]},
          {16'd0, PRIO ? 16'hAAAA : (i % 2 == 0 ? 16'h5555 : 16'hAAAA)});

    // Requester 1 arrives while requester 2 holds the grant with hold not exhausted
    pulse_reset();
    r1 = 1'b0; r2 = 1'b1; d2 = 16'h2222;
    repeat (3) tick();
    r1 = 1'b1; d2 = 16'h3333;
    tick();
    chk("g2_preempt_gnt1", {31'd0, b4.gnt1}, {31'd0, PRIO});
    chk("g2_last_xfer", {15'd0, b4.out_valid, b4.out}, {15'd0, 1'b1, 16'h3333});

    // Asynchronous reset in the middle of a G1 burst
    pulse_reset();
    r1 = 1'b1; r2 = 1'b0; d1 = 16'h7777;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    m[0] = reset_model();
    m[1] = reset_model();
    #1;
    chk("async_rst_h4", {27'd0, b4.gnt1, b4.gnt2, b4.switch, b4.out_valid, |b4.out}, 32'd0);
    chk("async_rst_h1", {27'd0, b1.gnt1, b1.gnt2, b1.switch, b1.out_valid, |b1.out}, 32'd0);
    r2 = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_tie", {30'd0, b4.gnt1, b4.gnt2}, 32'd2);

    for (int i = 0; i < 400; i++) begin
      r1 = $urandom_range(0, 3) != 0;
      r2 = $urandom_range(0, 3) != 0;
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
